dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 47 ++++
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types for the data-memory arbiter: controller state encoding, port
// identifiers, the registered strobe/ack bundle and the request check helper.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Controller states. WAIT covers the memory read latency after READ.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        READ,
        WAIT,
        RESP
    } state_t;

    // Port identifiers, also the encoding of the arbiter's last_grant.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Every single-cycle output pulse of the arbiter lives in one record so
    // it can be cleared in a single assignment each cycle.
    typedef struct packed {
        logic we;
        logic re;
        logic ack_a;
        logic ack_b;
        logic err;
    } strobe_t;

    // A request is rejected when the byte address is not word aligned or the
    // word index falls outside the memory.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input int unsigned words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= words);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. The grant is combinational from the current
// requests and the registered last_grant; last_grant only moves when the
// controller pulses update at the end of a transaction.
//
// Ports
//   clk, reset   clock and synchronous active-high reset
//   req_a/req_b  request lines of the two ports
//   update       one-cycle pulse: record update_port as the last grant
//   update_port  port that has just been served
//   grant_port   port that would be granted this cycle
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    input  logic update_port,
    output logic grant_port
);

    logic last_grant;

    // With both ports asking, the one not served last wins. Resetting
    // last_grant to B hands the very first tie to A.
    always_comb begin
        grant_port = PORT_A;
        if (req_a && req_b) begin
            grant_port = ~last_grant;
        end else if (req_b) begin
            grant_port = PORT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_B;
        end else if (update) begin
            last_grant <= update_port;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port, word-addressed data memory between port A (CPU
// load/store unit) and port B (debug/DMA loader). One transaction is handled
// at a time: grant, latch, check, strobe the memory, then acknowledge.
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_ack)
//   a_ack/a_err/a_rdata         port A completion pulse, error flag, load data
//   b_*                         same set for port B
//   mem_addr/mem_wdata          word index and write data to the memory
//   mem_we/mem_re               single-cycle write / read strobes
//   mem_rdata                   read data, valid READ_LAT cycles after mem_re
//
// Timing with the request seen in IDLE at cycle N:
//   error -> ack at N+2; store -> mem_we at N+2, ack at N+3;
//   load  -> mem_re at N+2, ack at N+3+READ_LAT.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter  int MEM_WORDS = 32,
    parameter  int READ_LAT  = 1,
    localparam int ADDR_W    = $clog2(MEM_WORDS)
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [31:0]       a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [31:0]       b_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    // The WAIT counter counts down to the cycle in which mem_rdata is valid.
    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    state_t      state;
    strobe_t     strb;

    logic        arb_grant;
    logic        arb_update;
    logic        gnt_port;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  wait_cnt;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_a       (a_req),
        .req_b       (b_req),
        .update      (arb_update),
        .update_port (gnt_port),
        .grant_port  (arb_grant)
    );

    // last_grant moves while the response is on the bus, so the IDLE cycle
    // that follows already sees the new priority.
    assign arb_update = (state == RESP);

    // Request fields of whichever port the arbiter currently picks.
    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (arb_grant == PORT_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    assign mem_we    = strb.we;
    assign mem_re    = strb.re;
    assign a_ack     = strb.ack_a;
    assign b_ack     = strb.ack_b;
    assign a_err     = strb.err & strb.ack_a;
    assign b_err     = strb.err & strb.ack_b;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            strb      <= '0;
            gnt_port  <= PORT_A;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            // Every strobe and ack is a one-cycle pulse unless re-armed below.
            strb <= '0;

            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        // Latch the winner; later input changes are ignored.
                        gnt_port  <= arb_grant;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        mem_addr  <= sel_addr[ADDR_W+1:2];
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (addr_err(lat_addr, MEM_WORDS)) begin
                        // Rejected requests skip the memory entirely.
                        strb.err   <= 1'b1;
                        strb.ack_a <= (gnt_port == PORT_A);
                        strb.ack_b <= (gnt_port == PORT_B);
                        state      <= RESP;
                    end else if (lat_we) begin
                        strb.we <= 1'b1;
                        state   <= WRITE;
                    end else begin
                        strb.re <= 1'b1;
                        state   <= READ;
                    end
                end

                WRITE: begin
                    strb.ack_a <= (gnt_port == PORT_A);
                    strb.ack_b <= (gnt_port == PORT_B);
                    state      <= RESP;
                end

                READ: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        // mem_rdata is valid in this cycle; only the granted
                        // port's register changes, the other one holds.
                        if (gnt_port == PORT_A) begin
                            a_rdata <= mem_rdata;
                        end else begin
                            b_rdata <= mem_rdata;
                        end
                        strb.ack_a <= (gnt_port == PORT_A);
                        strb.ack_b <= (gnt_port == PORT_B);
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                RESP: begin
                    mem_addr <= '0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized two-port traffic with occasional
// resets. A transaction-level model predicts, per cycle, every strobe, ack,
// error flag, word index and read-data register of the arbiter.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MW     = 32;
    localparam int RL     = 3;
    localparam int NCYC   = 8000;
    localparam int MAXLAT = RL + 6;
    localparam int FAIR_B = 2 * RL + 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ack, a_err;
    logic [31:0] a_rdata;

    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ack, b_err;
    logic [31:0] b_rdata;

    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata = '0;

    dmem_arbiter #(.MEM_WORDS(MW), .READ_LAT(RL)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory environment ----------------
    initial begin : mem_env
        logic [31:0] emem [MW];
        logic [31:0] pipe [RL];
        logic        re_s, we_s;
        logic [4:0]  ad_s;
        logic [31:0] wd_s;
        for (int i = 0; i < MW; i++) emem[i] = init_word(i);
        for (int i = 0; i < RL; i++) pipe[i] = '0;
        forever begin
            @(negedge clk);
            re_s = mem_re;
            we_s = mem_we;
            ad_s = mem_addr;
            wd_s = mem_wdata;
            @(posedge clk);
            #1;
            if (we_s === 1'b1) emem[ad_s] = wd_s;
            for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = (re_s === 1'b1) ? emem[ad_s] : $urandom;
            mem_rdata = pipe[RL-1];
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit        ack_a, ack_b, err, we, re, ld_a, ld_b, clr;
        bit [4:0]  addr;
        bit [4:0]  idx;
        bit [31:0] wd;
    } ev_t;

    ev_t         ev [NCYC + 64];
    ev_t         zero_ev;
    bit          last_b  = 1'b1;
    int          free_at = 0;
    logic [31:0] mmem [MW];
    logic [31:0] ra = '0, rb = '0;

    task automatic schedule(input int n);
        bit          gb, we, er;
        logic [31:0] ad, wd;
        bit [4:0]    ix;
        int          ackc;
        if (n + MAXLAT >= NCYC + 64) return;
        gb = (a_req && b_req) ? !last_b : b_req;
        we = gb ? b_we : a_we;
        ad = gb ? b_addr : a_addr;
        wd = gb ? b_wdata : a_wdata;
        ix = ad[6:2];
        er = (ad[1:0] != 2'b00) || ({2'b00, ad[31:2]} >= 32'(MW));
        if (er) begin
            ackc = n + 2;
        end else if (we) begin
            ackc = n + 3;
            ev[n+2].we  = 1'b1;
            ev[n+2].wd  = wd;
            ev[n+2].idx = ix;
        end else begin
            ackc = n + 3 + RL;
            ev[n+2].re   = 1'b1;
            ev[ackc].idx = ix;
            if (gb) ev[ackc].ld_b = 1'b1;
            else    ev[ackc].ld_a = 1'b1;
        end
        for (int c = n + 1; c <= ackc; c++) ev[c].addr = ix;
        if (gb) ev[ackc].ack_b = 1'b1;
        else    ev[ackc].ack_a = 1'b1;
        ev[ackc].err = er;
        free_at = ackc + 1;
        last_b  = gb;
    endtask

    initial begin : model
        ev_t e;
        int  k;
        for (int i = 0; i < MW; i++) mmem[i] = init_word(i);
        forever begin
            @(negedge clk);
            k = cyc;
            e = ev[k];
            if (e.clr) begin ra = '0; rb = '0; end
            if (e.we)   mmem[e.idx] = e.wd;
            if (e.ld_a) ra = mmem[e.idx];
            if (e.ld_b) rb = mmem[e.idx];
            if (chk_en) begin
                chk("a_ack",    32'(a_ack),    32'(e.ack_a));
                chk("a_err",    32'(a_err),    32'(e.ack_a & e.err));
                chk("b_ack",    32'(b_ack),    32'(e.ack_b));
                chk("b_err",    32'(b_err),    32'(e.ack_b & e.err));
                chk("mem_we",   32'(mem_we),   32'(e.we));
                chk("mem_re",   32'(mem_re),   32'(e.re));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("a_rdata",  a_rdata, ra);
                chk("b_rdata",  b_rdata, rb);
                chk("we_re_excl",  32'(mem_we & mem_re), 32'd0);
                chk("ack_excl",    32'(a_ack & b_ack),   32'd0);
                if (e.we) chk("mem_wdata", mem_wdata, e.wd);
            end
            if (reset) begin
                for (int c = k + 1; c <= k + MAXLAT && c < NCYC + 64; c++) ev[c] = zero_ev;
                if (k + 1 < NCYC + 64) ev[k+1].clr = 1'b1;
                free_at = k + 1;
                last_b  = 1'b1;
            end else if (k >= free_at && (a_req || b_req)) begin
                schedule(k);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_ack(input bit port_b, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (port_b ? b_ack : a_ack) begin
                at = cyc;
                break;
            end
        end
        tests++;
        if (at < 0) begin
            fails++;
            $display("FAIL ack_timeout port %0d: got no ack, required ack within %0d cycles", port_b, limit);
        end
    endtask

    task automatic gen_req(output logic we, output logic [31:0] addr, output logic [31:0] wd);
        int r;
        r  = $urandom_range(0, 9);
        we = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (r < 7)       addr = {25'b0, 5'($urandom_range(0, MW - 1)), 2'b00};
        else if (r == 7) addr = {25'b0, 5'($urandom_range(0, MW - 1)), 2'($urandom_range(1, 3))};
        else if (r == 8) addr = 32'($urandom_range(MW, 4 * MW)) << 2;
        else             addr = $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        int n, t1, t2, t3, got, na, nb, a_wait, b_wait;
        bit a_acked, b_acked;

        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // reset state
        at_neg(cyc);
        chk("rst_mem_addr",  32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_a_rdata",   a_rdata, 32'd0);
        chk("rst_b_rdata",   b_rdata, 32'd0);
        @(posedge clk);
        #1;

        // both ports together right after reset: A,B,A,B
        n = cyc;
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h1111_1111;
        b_req = 1; b_we = 1; b_addr = 32'h24; b_wdata = 32'h2222_2222;
        na = 0; nb = 0;
        for (int t = 0; t < 4; t++) begin
            got = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (a_ack || b_ack) begin got = cyc; break; end
            end
            tests++;
            if (got < 0) begin
                fails++;
                $display("FAIL rr_timeout: got no ack, required ack %0d", t);
            end else begin
                chk("rr_ack_cycle", 32'(got - n), 32'(3 + 4 * t));
                chk("rr_grant_b",   32'(b_ack), 32'(t % 2));
                if (b_ack) nb++; else na++;
            end
            @(posedge clk);
            #1;
            if (na == 2) a_req = 0;
            if (nb == 2) b_req = 0;
        end
        a_req = 0; b_req = 0;

        // store A 0x10
        goto_cycle(cyc + 1);
        n = cyc;
        a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF;
        at_neg(n + 2);
        chk("st_mem_we",    32'(mem_we), 32'd1);
        chk("st_mem_addr",  32'(mem_addr), 32'd4);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        at_neg(n + 3);
        chk("st_a_ack", 32'(a_ack), 32'd1);
        chk("st_a_err", 32'(a_err), 32'd0);
        @(posedge clk);
        #1;
        a_req = 0;

        // load A 0x10
        goto_cycle(cyc + 1);
        n = cyc;
        a_req = 1; a_we = 0; a_addr = 32'h10;
        at_neg(n + 2);
        chk("ld_mem_re",   32'(mem_re), 32'd1);
        chk("ld_mem_addr", 32'(mem_addr), 32'd4);
        at_neg(n + 3);
        chk("ld_re_width", 32'(mem_re), 32'd0);
        at_neg(n + 3 + RL);
        chk("ld_a_ack",   32'(a_ack), 32'd1);
        chk("ld_a_rdata", a_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        a_req = 0;

        // B errors: misaligned then out of range
        for (int t = 0; t < 2; t++) begin
            goto_cycle(cyc + 1);
            n = cyc;
            b_req = 1; b_we = (t == 0); b_addr = (t == 0) ? 32'h13 : 32'h80; b_wdata = 32'h5555_5555;
            at_neg(n + 1);
            chk("err_no_strobe1", 32'(mem_we | mem_re), 32'd0);
            at_neg(n + 2);
            chk("err_b_ack", 32'(b_ack), 32'd1);
            chk("err_b_err", 32'(b_err), 32'd1);
            chk("err_no_strobe2", 32'(mem_we | mem_re), 32'd0);
            @(posedge clk);
            #1;
            b_req = 0;
        end

        // reset during WAIT of an A load, then the re-presented load
        goto_cycle(cyc + 1);
        n = cyc;
        a_req = 1; a_we = 0; a_addr = 32'h10;
        goto_cycle(n + 4);
        reset = 1;
        at_neg(n + 5);
        chk("rw_a_ack",     32'(a_ack), 32'd0);
        chk("rw_a_rdata",   a_rdata, 32'd0);
        chk("rw_mem_addr",  32'(mem_addr), 32'd0);
        chk("rw_mem_wdata", mem_wdata, 32'd0);
        chk("rw_strobes",   32'(mem_we | mem_re), 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        wait_ack(1'b0, 30, got);
        chk("rw_ack_cycle", 32'(got - n), 32'(6 + 3 + RL));
        chk("rw_rdata",     a_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        a_req = 0;

        // back-to-back A loads
        goto_cycle(cyc + 1);
        n = cyc;
        a_req = 1; a_we = 0; a_addr = 32'h0C;
        wait_ack(1'b0, 30, t1);
        chk("b2b_first",  32'(t1 - n), 32'(3 + RL));
        chk("b2b_rdata0", a_rdata, 32'hA500_0003);
        @(posedge clk);
        #1;
        a_addr = 32'h14;
        wait_ack(1'b0, 30, t2);
        chk("b2b_spacing1", 32'(t2 - t1), 32'(4 + RL));
        chk("b2b_rdata1",   a_rdata, 32'hA500_0005);
        @(posedge clk);
        #1;
        a_addr = 32'h0C;
        wait_ack(1'b0, 30, t3);
        chk("b2b_spacing2", 32'(t3 - t2), 32'(4 + RL));
        @(posedge clk);
        #1;
        a_req = 0;

        // random two-port traffic
        a_wait = 0; b_wait = 0;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            a_acked = a_ack;
            b_acked = b_ack;
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (a_acked) begin
                chk("fair_a", 32'(a_wait <= FAIR_B), 32'd1);
                a_wait = 0;
                if ($urandom_range(0, 9) < 6) gen_req(a_we, a_addr, a_wdata);
                else a_req = 0;
            end else if (a_req) begin
                a_wait++;
                if (a_wait > 60) begin
                    tests++; fails++;
                    $display("FAIL stuck_a: got no ack after %0d cycles, required ack", a_wait);
                    a_req = 0; a_wait = 0;
                end
            end else if ($urandom_range(0, 9) < 3) begin
                gen_req(a_we, a_addr, a_wdata);
                a_req = 1; a_wait = 0;
            end
            if (b_acked) begin
                chk("fair_b", 32'(b_wait <= FAIR_B), 32'd1);
                b_wait = 0;
                if ($urandom_range(0, 9) < 6) gen_req(b_we, b_addr, b_wdata);
                else b_req = 0;
            end else if (b_req) begin
                b_wait++;
                if (b_wait > 60) begin
                    tests++; fails++;
                    $display("FAIL stuck_b: got no ack after %0d cycles, required ack", b_wait);
                    b_req = 0; b_wait = 0;
                end
            end else if ($urandom_range(0, 9) < 3) begin
                gen_req(b_we, b_addr, b_wdata);
                b_req = 1; b_wait = 0;
            end
            if ($urandom_range(0, 299) == 0) begin
                reset = 1;
                a_wait = 0;
                b_wait = 0;
            end
        end

        a_req = 0; b_req = 0; reset = 0;
        repeat (20) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
